led_pattern_sequencer: RTL and testbench

- Downstream consumer of the board's slow divided clock: takes the divider's square-wave output as a step request and drives the 8 user LEDs on the ECP3 Versa with a selectable animated pattern.
- Runs entirely in the main clk domain.
- The divider output is treated as a data signal, never as a clock; only its rising edge advances the pattern.

---
 rtl/led_pattern_sequencer_pkg.sv | 31 +++
 rtl/led_pattern_sequencer_if.sv | 15 +
 rtl/led_pattern_sequencer_pwm.sv | 25 ++
 rtl/led_pattern_sequencer.sv | 108 ++++++++++
 tb/tb_led_pattern_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and reset-time patterns for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BINARY = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int INIT_BINARY = 0;
  localparam int INIT_BOUNCE = 1;
  localparam int INIT_BLINK  = 0;
  localparam int INIT_FILL   = 0;

  // Pattern value loaded whenever the selected mode changes.
  function automatic int initPattern(mode_e m);
    case (m)
      MODE_BOUNCE: return INIT_BOUNCE;
      MODE_BLINK:  return INIT_BLINK;
      MODE_FILL:   return INIT_FILL;
      default:     return INIT_BINARY;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control/status bundle between the pattern sequencer and whatever drives it.
interface led_pattern_sequencer_if #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 4
);
  logic                tick_in;
  logic [1:0]          mode;
  logic                hold;
  logic [PWM_BITS-1:0] duty;
  logic [NUM_LEDS-1:0] leds_n;
  logic                step_o;

  modport master (output tick_in, mode, hold, duty, input leds_n, step_o);
  modport slave  (input tick_in, mode, hold, duty, output leds_n, step_o);
endinterface

// File: rtl/led_pattern_sequencer_pwm.sv
// Brightness dimmer: free-running counter gates the pattern while below duty.
module led_pwm #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [NUM_LEDS-1:0] pattern,
  output logic [NUM_LEDS-1:0] lit
);

  logic [PWM_BITS-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
    end
  end

  assign lit = pattern & {NUM_LEDS{cnt_q < duty}};

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps an animated LED pattern on each rising edge of the divided tick.
// Define LED_PWM_EN to dim the LEDs with the duty input (adds one cycle on leds_n).
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  led_pattern_sequencer_if.slave  bus
);

  logic                tick_q;
  mode_e               mode_q;
  dir_e                dir_q, dir_d;
  logic [NUM_LEDS-1:0] pattern_q, pattern_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                step_q, step_d;

  logic                step;
  logic                modeChange;
  mode_e               modeIn;
  logic [NUM_LEDS-1:0] advanced;
  dir_e                advancedDir;

  assign modeIn     = mode_e'(bus.mode);
  assign step       = bus.tick_in & ~tick_q;
  assign modeChange = (modeIn != mode_q);

  always_comb begin
    advanced    = pattern_q;
    advancedDir = dir_q;
    case (mode_q)
      MODE_BINARY: advanced = pattern_q + NUM_LEDS'(1);
      MODE_BOUNCE: begin
        // Direction flips on the same step that lands on an end bit.
        if (dir_q == DIR_UP) begin
          advanced = pattern_q << 1;
          if (pattern_q[NUM_LEDS-2]) advancedDir = DIR_DOWN;
        end else begin
          advanced = pattern_q >> 1;
          if (pattern_q[1]) advancedDir = DIR_UP;
        end
      end
      MODE_BLINK:  advanced = ~pattern_q;
      MODE_FILL:   advanced = (&pattern_q) ? '0 : {pattern_q[NUM_LEDS-2:0], 1'b1};
      default:     advanced = pattern_q;
    endcase
  end

  always_comb begin
    pattern_d = pattern_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    if (modeChange) begin
      pattern_d = NUM_LEDS'(initPattern(modeIn));
      dir_d     = DIR_UP;
    end else if (step && !bus.hold) begin
      pattern_d = advanced;
      dir_d     = advancedDir;
      step_d    = 1'b1;
    end
  end

`ifdef LED_PWM_EN
  logic [NUM_LEDS-1:0] lit;

  led_pwm #(
    .NUM_LEDS (NUM_LEDS),
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .duty    (bus.duty),
    .pattern (pattern_q),
    .lit     (lit)
  );

  assign leds_d = ~lit;
`else
  logic unusedDuty;
  assign unusedDuty = ^bus.duty;
  assign leds_d     = ~pattern_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q    <= 1'b0;
      mode_q    <= MODE_BINARY;
      pattern_q <= '0;
      dir_q     <= DIR_UP;
      leds_q    <= '1;
      step_q    <= 1'b0;
    end else begin
      tick_q    <= bus.tick_in;
      mode_q    <= modeIn;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      leds_q    <= leds_d;
      step_q    <= step_d;
    end
  end

  assign bus.leds_n = leds_q;
  assign bus.step_o = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: a counter-based pattern model checked every cycle plus literal pins.
module tb_led_pattern_sequencer;

  localparam int NUM_LEDS = 8;
  localparam int PWM_BITS = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   stepPulses = 0;

  led_pattern_sequencer_if #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS)) bus ();

  led_pattern_sequencer #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each mode is a cyclic sequence; the model tracks only the mode and its position.
  function automatic int periodOf(input int m);
    case (m)
      0:       return 1 << NUM_LEDS;
      1:       return 2 * NUM_LEDS - 2;
      2:       return 2;
      default: return NUM_LEDS + 1;
    endcase
  endfunction

  function automatic logic [NUM_LEDS-1:0] patternOf(input int m, input int c);
    int pos;
    case (m)
      0: return NUM_LEDS'(c);
      1: begin
        pos = (c < NUM_LEDS) ? c : 2 * NUM_LEDS - 2 - c;
        return NUM_LEDS'(1 << pos);
      end
      2:       return (c % 2 == 1) ? '1 : '0;
      default: return NUM_LEDS'((1 << c) - 1);
    endcase
  endfunction

  int                  mMode;
  int                  mCount;
  int                  mCnt;
  logic                mPrevTick;
  logic                mStep;
  logic                mValid = 1'b0;
  logic [NUM_LEDS-1:0] mPattern;
  logic [NUM_LEDS-1:0] mLeds;

  always @(posedge clk) begin
    logic stepEv;
    if (!rst_n) begin
      mMode = 0; mCount = 0; mCnt = 0; mPrevTick = 1'b0; mStep = 1'b0;
      mLeds = '1; mValid = 1'b1;
    end else begin
`ifdef LED_PWM_EN
      mLeds = ~(patternOf(mMode, mCount) & ((mCnt < int'(bus.duty)) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}}));
      mCnt  = (mCnt + 1) % (1 << PWM_BITS);
`endif
      stepEv    = bus.tick_in && !mPrevTick;
      mPrevTick = bus.tick_in;
      mStep     = 1'b0;
      if (int'(bus.mode) != mMode) begin
        mMode  = int'(bus.mode);
        mCount = 0;
      end else if (stepEv && !bus.hold) begin
        mCount = (mCount + 1) % periodOf(mMode);
        mStep  = 1'b1;
      end
`ifndef LED_PWM_EN
      mLeds = ~patternOf(mMode, mCount);
`endif
    end
    mPattern = patternOf(mMode, mCount);
  end

  always @(negedge clk) begin
    if (mValid) begin
      checks++;
      if (bus.leds_n !== mLeds) begin
        errors++;
        $display("[TB] FAIL leds_n at %0t: got %h expected %h", $time, bus.leds_n, mLeds);
      end
      checks++;
      if (bus.step_o !== mStep) begin
        errors++;
        $display("[TB] FAIL step_o at %0t: got %b expected %b", $time, bus.step_o, mStep);
      end
      if (bus.step_o === 1'b1) stepPulses++;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int ticks, input int holdCycles);
    for (int i = 0; i < ticks; i++) begin
      bus.tick_in = 1'b1;
      waitCycles(holdCycles);
      bus.tick_in = 1'b0;
      waitCycles(holdCycles);
    end
  endtask

  task automatic checkOutput(input string name, input logic [NUM_LEDS-1:0] expPattern, input logic expStep);
    checks++;
    if (mPattern !== expPattern) begin
      errors++;
      $display("[TB] FAIL %s model pattern: got %h expected %h", name, mPattern, expPattern);
    end
`ifndef LED_PWM_EN
    checks++;
    if (bus.leds_n !== ~expPattern) begin
      errors++;
      $display("[TB] FAIL %s leds_n: got %h expected %h", name, bus.leds_n, ~expPattern);
    end
`endif
    checks++;
    if (bus.step_o !== expStep) begin
      errors++;
      $display("[TB] FAIL %s step_o: got %b expected %b", name, bus.step_o, expStep);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int expected);
    checks++;
    if (got != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, expected);
    end
  endtask

  logic [NUM_LEDS-1:0] bounceSeq [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                          8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  logic [NUM_LEDS-1:0] fillSeq [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

  initial begin
    int s0;
    rst_n = 1'b0;
    bus.tick_in = 1'b0;
    bus.mode = 2'b00;
    bus.hold = 1'b0;
    bus.duty = 4'd4;
    waitCycles(3);
    rst_n = 1'b1;
    checkOutput("reset", 8'h00, 1'b0);
    waitCycles(5);
    checkOutput("idle", 8'h00, 1'b0);

    s0 = stepPulses;
    applyStimulus(1, 10);
    checkOutput("bin01", 8'h01, 1'b0);
    applyStimulus(254, 10);
    checkOutput("binFF", 8'hFF, 1'b0);
    applyStimulus(1, 10);
    checkOutput("binWrap", 8'h00, 1'b0);
    checkCount("binSteps", stepPulses - s0, 256);

    bus.mode = 2'b01;
    waitCycles(2);
    checkOutput("bounceInit", 8'h01, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 10);
      checkOutput($sformatf("bounce%0d", i), bounceSeq[i], 1'b0);
    end

    bus.mode = 2'b11;
    waitCycles(2);
    checkOutput("fillInit", 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 10);
      checkOutput($sformatf("fill%0d", i), fillSeq[i], 1'b0);
    end

    s0 = stepPulses;
    bus.mode = 2'b10;
    bus.tick_in = 1'b1;
    waitCycles(1);
    checkOutput("blinkSwitch", 8'h00, 1'b0);
    waitCycles(9);
    bus.tick_in = 1'b0;
    waitCycles(10);
    checkCount("switchSteps", stepPulses - s0, 0);
    applyStimulus(1, 10);
    checkOutput("blinkFF", 8'hFF, 1'b0);

`ifdef LED_PWM_EN
    begin
      int litCycles;
      litCycles = 0;
      for (int i = 0; i < 16; i++) begin
        waitCycles(1);
        if (bus.leds_n == 8'h00) litCycles++;
      end
      checkCount("pwmDuty4", litCycles, 4);
      bus.duty = 4'd0;
      waitCycles(2);
      litCycles = 0;
      for (int i = 0; i < 16; i++) begin
        waitCycles(1);
        if (bus.leds_n != 8'hFF) litCycles++;
      end
      checkCount("pwmDuty0", litCycles, 0);
      bus.duty = 4'd4;
    end
`endif

    bus.mode = 2'b00;
    waitCycles(2);
    applyStimulus(5, 10);
    checkOutput("hold05", 8'h05, 1'b0);
    s0 = stepPulses;
    bus.hold = 1'b1;
    applyStimulus(5, 10);
    checkOutput("held05", 8'h05, 1'b0);
    checkCount("holdSteps", stepPulses - s0, 0);
    bus.hold = 1'b0;
    applyStimulus(1, 10);
    checkOutput("release06", 8'h06, 1'b0);

    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("midReset", 8'h00, 1'b0);
    rst_n = 1'b1;
    bus.mode = 2'b01;
    waitCycles(2);
    checkOutput("postResetBounce", 8'h01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
